// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory and IF/ID bundle of the fetch stage
interface if_fetch_stage_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;

  // master is the fetch stage; slave is the memory/decode side
  modport master (
    output imem_addr_o,
    input  imem_rdata_i,
    output if_id_instr_o,
    output if_id_pc4_o,
    output if_id_valid_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_rdata_i,
    input  if_id_instr_o,
    input  if_id_pc4_o,
    input  if_id_valid_o
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, IF/ID register, stall/flush/redirect, halt
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_target_i,
  if_fetch_stage_if.master       fetch_if,
  output logic [31:0]            pc_o,
  output logic                   halted_o,
  output logic                   misalign_o,
  output logic [31:0]            fetch_count_o
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        load_valid;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    load_valid = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect_valid_i) begin
          // redirect wins over stall/flush and discards whatever was fetched
          pc_d    = {redirect_target_i[31:2], 2'b00};
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          if (redirect_target_i[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (stall_i && flush_i) begin
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (flush_i) begin
          pc_d    = pc_plus4;
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else begin
          instr_d    = fetch_if.imem_rdata_i;
          pc4_d      = pc_plus4;
          valid_d    = 1'b1;
          load_valid = 1'b1;
          // the halt word itself still goes to decode; only the PC freezes
          if (fetch_if.imem_rdata_i == HALT_WORD) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HALT: begin
        instr_d = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    count_d = count_q;
    if (load_valid && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign fetch_if.imem_addr_o   = pc_q;
  assign fetch_if.if_id_instr_o = instr_q;
  assign fetch_if.if_id_pc4_o   = pc4_q;
  assign fetch_if.if_id_valid_o = valid_q;
  assign pc_o                   = pc_q;
  assign halted_o               = halted_q;
  assign misalign_o             = misalign_q;
  assign fetch_count_o          = count_q;

endmodule
